// File: rtl/signal_conditioner_pkg.sv
// Shared definitions for the pad-input conditioning path.
// - ST_IDLE / ST_SETTLE: filter state encoding. It follows the same style as state_monitor.
// - state_t: enum typed on those encodings.
// - DEBOUNCE_DEFAULT: suggested debounce length (20 samples = 2 ms at 10 kHz).
package signal_conditioner_pkg;

  localparam logic ST_IDLE   = 1'b0;
  localparam logic ST_SETTLE = 1'b1;

  typedef enum logic {
    FSM_IDLE   = ST_IDLE,
    FSM_SETTLE = ST_SETTLE
  } state_t;

  localparam logic [7:0] DEBOUNCE_DEFAULT = 8'd20;

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchroniser for an asynchronous pad input. It is reused for other pads.
// Ports:
//   i_clk   - destination clock
//   i_reset - synchronous active-high reset (clears the whole chain)
//   i_d     - asynchronous input
//   o_q     - synchronised output (last stage)
// SYNC_STAGES must be 2..4.
module sync_chain #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_d,
  output logic o_q
);

  logic [SYNC_STAGES-1:0] chain_r;

  // Shift the raw input through the synchroniser flops.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      chain_r <= {SYNC_STAGES{1'b0}};
    end else begin
      chain_r <= {chain_r[SYNC_STAGES-2:0], i_d};
    end
  end

  assign o_q = chain_r[SYNC_STAGES-1];

endmodule

// File: rtl/signal_conditioner.sv
// Input conditioner that feeds state_monitor's i_signal.
// The asynchronous pad input is synchronised, then a level change is accepted
// only after i_debounce_len consecutive stable samples. The block produces a
// clean level plus rise/fall strobes, and counts rejected glitches.
// Ports:
//   i_clk, i_reset       - clock and synchronous active-high reset
//   i_signal_raw         - asynchronous pad input
//   i_enable             - 1 = filter runs; 0 = hold level, no strobes
//   i_debounce_len       - stable samples required to accept a change (read live)
//   i_clear_glitch       - synchronous clear of o_glitch_count (wins over increment)
//   o_signal             - debounced level
//   o_rise / o_fall      - one-cycle strobes aligned with the o_signal change
//   o_stable             - 1 while the filter is idle (no pending change)
//   o_glitch_count       - saturating count of rejected pulses
module signal_conditioner
  import signal_conditioner_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE_W  = 8,
  parameter int GLITCH_W    = 8
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_signal_raw,
  input  logic                  i_enable,
  input  logic [DEBOUNCE_W-1:0] i_debounce_len,
  input  logic                  i_clear_glitch,
  output logic                  o_signal,
  output logic                  o_rise,
  output logic                  o_fall,
  output logic                  o_stable,
  output logic [GLITCH_W-1:0]   o_glitch_count
);

  logic                  s_s;
  state_t                state_r;
  logic [DEBOUNCE_W-1:0] cnt_r;
  logic                  signal_r;
  logic                  rise_r;
  logic                  fall_r;
  logic                  stable_r;
  logic [GLITCH_W-1:0]   glitch_r;

  logic [DEBOUNCE_W:0]   cnt_next_s;
  logic [DEBOUNCE_W:0]   len_ext_s;
  logic                  len_le_one_s;
  logic                  settle_done_s;
  logic                  glitch_s;
  logic                  glitch_sat_s;

  sync_chain #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .i_d    (i_signal_raw),
    .o_q    (s_s)
  );

  // Compare one bit wider than the counter so counter + 1 cannot wrap.
  assign cnt_next_s    = {1'b0, cnt_r} + {{DEBOUNCE_W{1'b0}}, 1'b1};
  assign len_ext_s     = {1'b0, i_debounce_len};
  assign settle_done_s = (cnt_next_s >= len_ext_s);
  assign len_le_one_s  = (i_debounce_len <= {{(DEBOUNCE_W-1){1'b0}}, 1'b1});

  // A glitch is the synchronised level returning to o_signal before settling.
  // A SETTLE abandoned because the filter was disabled is not a glitch.
  assign glitch_s     = i_enable && (state_r == FSM_SETTLE) && (s_s == signal_r);
  assign glitch_sat_s = (glitch_r == {GLITCH_W{1'b1}});

  // Debounce FSM with the settle counter, the registered level, the strobes and the stable flag.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_r  <= FSM_IDLE;
      cnt_r    <= {DEBOUNCE_W{1'b0}};
      signal_r <= 1'b0;
      rise_r   <= 1'b0;
      fall_r   <= 1'b0;
      stable_r <= 1'b1;
    end else begin
      rise_r <= 1'b0;
      fall_r <= 1'b0;
      if (!i_enable) begin
        // Level is held. A pending change is dropped, and the next mismatch starts a fresh settle.
        state_r  <= FSM_IDLE;
        cnt_r    <= {DEBOUNCE_W{1'b0}};
        stable_r <= 1'b1;
      end else begin
        case (state_r)
          FSM_IDLE: begin
            if (s_s != signal_r) begin
              if (len_le_one_s) begin
                signal_r <= s_s;
                rise_r   <= s_s;
                fall_r   <= ~s_s;
                cnt_r    <= {DEBOUNCE_W{1'b0}};
                state_r  <= FSM_IDLE;
                stable_r <= 1'b1;
              end else begin
                cnt_r    <= {{(DEBOUNCE_W-1){1'b0}}, 1'b1};
                state_r  <= FSM_SETTLE;
                stable_r <= 1'b0;
              end
            end else begin
              cnt_r    <= {DEBOUNCE_W{1'b0}};
              state_r  <= FSM_IDLE;
              stable_r <= 1'b1;
            end
          end
          FSM_SETTLE: begin
            if (s_s != signal_r) begin
              if (settle_done_s) begin
                signal_r <= s_s;
                rise_r   <= s_s;
                fall_r   <= ~s_s;
                cnt_r    <= {DEBOUNCE_W{1'b0}};
                state_r  <= FSM_IDLE;
                stable_r <= 1'b1;
              end else begin
                cnt_r    <= cnt_next_s[DEBOUNCE_W-1:0];
                state_r  <= FSM_SETTLE;
                stable_r <= 1'b0;
              end
            end else begin
              cnt_r    <= {DEBOUNCE_W{1'b0}};
              state_r  <= FSM_IDLE;
              stable_r <= 1'b1;
            end
          end
          default: begin
            cnt_r    <= {DEBOUNCE_W{1'b0}};
            state_r  <= FSM_IDLE;
            stable_r <= 1'b1;
          end
        endcase
      end
    end
  end

  // Saturating glitch counter. A clear wins over a simultaneous increment.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      glitch_r <= {GLITCH_W{1'b0}};
    end else if (i_clear_glitch) begin
      glitch_r <= {GLITCH_W{1'b0}};
    end else if (glitch_s && !glitch_sat_s) begin
      glitch_r <= glitch_r + {{(GLITCH_W-1){1'b0}}, 1'b1};
    end else begin
      glitch_r <= glitch_r;
    end
  end

  assign o_signal       = signal_r;
  assign o_rise         = rise_r;
  assign o_fall         = fall_r;
  assign o_stable       = stable_r;
  assign o_glitch_count = glitch_r;

endmodule

// File: tb/tb_signal_conditioner.sv
// Directed testbench for signal_conditioner with the default parameters.
// Inputs are driven and outputs are sampled 1 time unit after each rising edge.
// A raw change driven after edge 0 is expected to commit on edge SYNC_STAGES + max(len,1).
module tb_signal_conditioner;

  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       raw;
  logic       en;
  logic [7:0] len;
  logic       clr;
  logic       sig;
  logic       rise;
  logic       fall;
  logic       stable;
  logic [7:0] gcnt;

  int tests = 0;
  int fails = 0;

  signal_conditioner #(
    .SYNC_STAGES(SYNC),
    .DEBOUNCE_W (8),
    .GLITCH_W   (8)
  ) dut (
    .i_clk         (clk),
    .i_reset       (rst),
    .i_signal_raw  (raw),
    .i_enable      (en),
    .i_debounce_len(len),
    .i_clear_glitch(clr),
    .o_signal      (sig),
    .o_rise        (rise),
    .o_fall        (fall),
    .o_stable      (stable),
    .o_glitch_count(gcnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // The raw level was just changed to lvl after an edge. Expect the commit on edge n, then the strobe clears.
  task automatic run_commit(input logic lvl, input int n, input string tag);
    for (int k = 1; k <= n; k++) begin
      tick();
      if (k < n) chk($sformatf("%s hold e%0d", tag, k), {29'd0, sig, rise, fall}, {29'd0, ~lvl, 2'b00});
      else       chk($sformatf("%s commit e%0d", tag, k), {29'd0, sig, rise, fall}, {29'd0, lvl, lvl, ~lvl});
    end
    tick();
    chk($sformatf("%s post", tag), {29'd0, sig, rise, fall}, {29'd0, lvl, 2'b00});
  endtask

  // Short raw pulse to the opposite level of o_signal. It is rejected as a glitch at edge 5 when len >= 4.
  task automatic glitch_pulse(input logic base);
    raw = ~base;
    tick(); tick();
    raw = base;
    tick(); tick(); tick(); tick();
  endtask

  initial begin
    rst = 1'b1; raw = 1'b0; en = 1'b1; len = 8'd5; clr = 1'b0;
    tick(); tick();
    chk("reset outputs", {27'd0, sig, rise, fall, stable}, {27'd0, 4'b0001});
    chk("reset gcnt", {24'd0, gcnt}, 32'd0);
    rst = 1'b0;
    tick(); tick();

    // 1: rising change with len 5 commits SYNC+5 edges later.
    raw = 1'b1;
    run_commit(1'b1, SYNC + 5, "t1 rise");
    chk("t1 gcnt", {24'd0, gcnt}, 32'd0);
    chk("t1 stable", {31'd0, stable}, 32'd1);
    raw = 1'b0;
    run_commit(1'b0, SYNC + 5, "t1 fall");

    // 2: a 3-cycle pulse is rejected.
    raw = 1'b1;
    tick(); tick(); tick();
    raw = 1'b0;
    tick(); tick();
    chk("t2 settling", {31'd0, stable}, 32'd0);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("t2 no strobe", {30'd0, rise, fall}, 32'd0);
    end
    chk("t2 level", {31'd0, sig}, 32'd0);
    chk("t2 gcnt", {24'd0, gcnt}, 32'd1);
    chk("t2 stable", {31'd0, stable}, 32'd1);

    // 3: len 0 and len 1 commit on the first mismatching sample.
    len = 8'd0;
    raw = 1'b1; run_commit(1'b1, SYNC + 1, "t3 len0 rise");
    raw = 1'b0; run_commit(1'b0, SYNC + 1, "t3 len0 fall");
    len = 8'd1;
    raw = 1'b1; run_commit(1'b1, SYNC + 1, "t3 len1 rise");
    raw = 1'b0; run_commit(1'b0, SYNC + 1, "t3 len1 fall");
    chk("t3 gcnt", {24'd0, gcnt}, 32'd1);

    // 4: 260 glitches saturate the counter. Then a clear beats a coincident glitch.
    len = 8'd5;
    for (int i = 0; i < 260; i++) begin
      glitch_pulse(1'b0);
      if (i == 252) chk("t4 gcnt 254", {24'd0, gcnt}, 32'd254);
      if (i == 253) chk("t4 gcnt 255", {24'd0, gcnt}, 32'd255);
    end
    chk("t4 saturated", {24'd0, gcnt}, 32'd255);
    chk("t4 level", {31'd0, sig}, 32'd0);
    raw = 1'b1; tick(); tick();
    raw = 1'b0; tick(); tick();
    clr = 1'b1; tick();
    clr = 1'b0;
    chk("t4 clear vs glitch sat", {24'd0, gcnt}, 32'd0);
    tick();
    glitch_pulse(1'b0);
    chk("t4 glitch after clear", {24'd0, gcnt}, 32'd1);
    raw = 1'b1; tick(); tick();
    raw = 1'b0; tick(); tick();
    clr = 1'b1; tick();
    clr = 1'b0;
    chk("t4 clear vs glitch", {24'd0, gcnt}, 32'd0);
    tick(); tick();

    // 5: disabling 4 cycles into SETTLE drops the change. It settles afresh after re-enable.
    len = 8'd10;
    raw = 1'b1;
    for (int k = 0; k < SYNC + 4; k++) tick();
    chk("t5 settling", {31'd0, stable}, 32'd0);
    en = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("t5 disabled", {29'd0, sig, rise, fall}, 32'd0);
    end
    chk("t5 disabled stable", {31'd0, stable}, 32'd1);
    chk("t5 disabled gcnt", {24'd0, gcnt}, 32'd0);
    en = 1'b1;
    run_commit(1'b1, 10, "t5 reenable");
    chk("t5 gcnt", {24'd0, gcnt}, 32'd0);

    // 6: a reset during a pending fall clears everything with no strobe.
    len = 8'd5;
    glitch_pulse(1'b1);
    chk("t6 pre gcnt", {24'd0, gcnt}, 32'd1);
    raw = 1'b0;
    for (int k = 0; k < SYNC + 3; k++) tick();
    chk("t6 pending", {30'd0, sig, stable}, {30'd0, 2'b10});
    rst = 1'b1;
    tick();
    chk("t6 reset outputs", {27'd0, sig, rise, fall, stable}, {27'd0, 4'b0001});
    chk("t6 reset gcnt", {24'd0, gcnt}, 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("t6 quiet", {29'd0, sig, rise, fall}, 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
